// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I integer ALU slice.
// Holds the opcode values, Funct3 encodings and the immediate sign-extension helper.
package alu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IMM_W   = 12;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    Funct3AddSub = 3'b000,
    Funct3Sll    = 3'b001,
    Funct3Slt    = 3'b010,
    Funct3Sltu   = 3'b011,
    Funct3Xor    = 3'b100,
    Funct3SrlSra = 3'b101,
    Funct3Or     = 3'b110,
    Funct3And    = 3'b111
  } funct3_e;

  function automatic logic [WIDTH-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the register file, the ALU and write-back.
// The master drives decoded instruction fields and operands; the slave returns RD.
interface alu_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] RS1;
  logic [WIDTH-1:0] RS2;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic [IMM_W-1:0] Imm_reg;
  logic [6:0]       opcode;
  logic [WIDTH-1:0] RD;

  modport master (
    output RS1, RS2, Funct3, Funct7, Imm_reg, opcode,
    input  RD
  );

  modport slave (
    input  RS1, RS2, Funct3, Funct7, Imm_reg, opcode,
    output RD
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational RV32I arithmetic/logic/shift unit.
// alt selects SUB over ADD and SRA over SRL; the caller decides when that is legal.
module alu_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  funct3_e          op,
  input  logic             alt,
  output logic [WIDTH-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    unique case (op)
      Funct3AddSub: result = alt ? (a - b) : (a + b);
      Funct3Sll:    result = a << shamt;
      Funct3Slt:    result = {{(WIDTH - 1){1'b0}}, $signed(a) < $signed(b)};
      Funct3Sltu:   result = {{(WIDTH - 1){1'b0}}, a < b};
      Funct3Xor:    result = a ^ b;
      Funct3SrlSra: result = alt ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      Funct3Or:     result = a | b;
      Funct3And:    result = a & b;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Registered RV32I ALU: decodes OP/OP-IMM, selects operand B and registers the result on RD.
// Unsupported opcodes and reset both load RD with zero.
module alu_top
  import alu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  logic             is_op;
  logic             is_op_imm;
  funct3_e          op;
  logic             alt;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  assign is_op     = (bus.opcode == OP);
  assign is_op_imm = (bus.opcode == OP_IMM);
  assign op        = funct3_e'(bus.Funct3);
  assign operand_b = is_op_imm ? sign_ext_imm(bus.Imm_reg) : bus.RS2;

  // OP-IMM has no SUBI; only the shift-right encoding honours the alternate bit.
  always_comb begin
    alt = 1'b0;
    if (is_op) begin
      alt = bus.Funct7[5];
    end else if (is_op_imm && (op == Funct3SrlSra)) begin
      alt = bus.Imm_reg[10];
    end
  end

  alu_core u_alu_core (
    .a      (bus.RS1),
    .b      (operand_b),
    .op     (op),
    .alt    (alt),
    .result (core_result)
  );

  assign rd_d = (is_op || is_op_imm) ? core_result : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.RD = rd_q;

  logic unused_funct7;
  assign unused_funct7 = ^{bus.Funct7[6], bus.Funct7[4:0]};

endmodule

// File: tb/tb_alu_top.sv
// Bench for alu_top: directed steps from the test plan, then random instructions
// checked against an arithmetic reference model.
module tb_alu_top;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_if bus ();

  alu_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model works on 64-bit integers so wraparound and sign are explicit.
  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [11:0] imm,
                                          input logic [31:0] a, input logic [31:0] rs2);
    longint two32, ua, ub, sa, sb, r;
    int     ib, sh;
    bit     is_r, alt;
    two32 = 64'h1_0000_0000;
    if (opc == 7'b0110011) is_r = 1'b1;
    else if (opc == 7'b0010011) is_r = 1'b0;
    else return 32'h0;
    ua = longint'({32'h0, a});
    sa = (ua >= 64'h8000_0000) ? ua - two32 : ua;
    if (is_r) begin
      ub  = longint'({32'h0, rs2});
      sb  = (ub >= 64'h8000_0000) ? ub - two32 : ub;
      alt = f7[5];
    end else begin
      ib  = int'({20'h0, imm});
      if (ib >= 2048) ib = ib - 4096;
      sb  = longint'(ib);
      ub  = (sb < 0) ? sb + two32 : sb;
      alt = (f3 == 3'd5) ? imm[10] : 1'b0;
    end
    sh = int'(ub % 32);
    case (f3)
      3'd0:    r = alt ? ua - ub : ua + ub;
      3'd1:    r = ua * (longint'(1) << sh);
      3'd2:    r = (sa < sb) ? 1 : 0;
      3'd3:    r = (ua < ub) ? 1 : 0;
      3'd4:    r = ua ^ ub;
      3'd5:    r = alt ? (sa >>> sh) : (ua / (longint'(1) << sh));
      3'd6:    r = ua | ub;
      default: r = ua & ub;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [11:0] imm, input logic [31:0] a, input logic [31:0] b);
    bus.opcode  = opc;
    bus.Funct3  = f3;
    bus.Funct7  = f7;
    bus.Imm_reg = imm;
    bus.RS1     = a;
    bus.RS2     = b;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (bus.RD === exp)
    else begin
      n_fail++;
      $error("FAIL %s: RD=%h expected %h", tag, bus.RD, exp);
    end
  endtask

  // Issue one instruction, clock it in, and compare RD against the model.
  task automatic step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [11:0] imm, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    drive(opc, f3, f7, imm, a, b);
    @(posedge clk);
    #1;
    check(tag, exp);
    check({tag, "_model"}, ref_alu(opc, f3, f7, imm, a, b));
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] a, b;

    rst = 1'b1;
    drive(OP, 3'd0, 7'h00, 12'h000, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk); #1;
    check("reset_edge1", 32'h0);
    @(posedge clk); #1;
    check("reset_edge2", 32'h0);
    rst = 1'b0;

    step("add_after_reset", OP, 3'd0, 7'h00, 12'h000, 32'd5, 32'd7, 32'd12);
    step("add_wrap", OP, 3'd0, 7'h00, 12'h000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    step("sub", OP, 3'd0, 7'h20, 12'h000, 32'd3, 32'd5, 32'hFFFF_FFFE);
    step("slt", OP, 3'd2, 7'h00, 12'h000, 32'hFFFF_FFFF, 32'h1, 32'h1);
    step("sltu", OP, 3'd3, 7'h00, 12'h000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    step("sll_low5", OP, 3'd1, 7'h00, 12'h000, 32'h1, 32'h21, 32'h2);
    step("srl", OP, 3'd5, 7'h00, 12'h000, 32'h8000_0000, 32'h4, 32'h0800_0000);
    step("sra", OP, 3'd5, 7'h20, 12'h000, 32'h8000_0000, 32'h4, 32'hF800_0000);
    step("srai", OP_IMM, 3'd5, 7'h20, 12'h404, 32'h8000_0000, 32'h0, 32'hF800_0000);
    step("srli", OP_IMM, 3'd5, 7'h00, 12'h004, 32'h8000_0000, 32'h0, 32'h0800_0000);
    step("sll_zero", OP, 3'd1, 7'h00, 12'h000, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
    step("addi", OP_IMM, 3'd0, 7'h7F, 12'hFFF, 32'd10, 32'h0, 32'd9);
    step("sltiu", OP_IMM, 3'd3, 7'h7F, 12'hFFF, 32'd5, 32'h0, 32'h1);
    step("slti", OP_IMM, 3'd2, 7'h7F, 12'hFFF, 32'd5, 32'h0, 32'h0);
    step("andi", OP_IMM, 3'd7, 7'h07, 12'h0FF, 32'h1234_5678, 32'h0, 32'h78);
    step("xori", OP_IMM, 3'd4, 7'h40, 12'h800, 32'h1234_5678, 32'h0,
         32'h1234_5678 ^ 32'hFFFF_F800);
    step("and", OP, 3'd7, 7'h00, 12'h000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    step("or", OP, 3'd6, 7'h00, 12'h000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    step("xor", OP, 3'd4, 7'h5F, 12'h000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    step("bad_opcode", 7'b0000011, 3'd0, 7'h00, 12'h000, 32'd5, 32'd7, 32'h0);
    step("add_again", OP, 3'd0, 7'h00, 12'h000, 32'd1, 32'd2, 32'd3);

    // Reset must win over a valid operation presented at the same edge.
    rst = 1'b1;
    drive(OP, 3'd0, 7'h00, 12'h000, 32'd100, 32'd200);
    @(posedge clk); #1;
    check("reset_in_flight", 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       opc = 7'($urandom);
        1, 2, 3,
        4:       opc = OP;
        default: opc = OP_IMM;
      endcase
      f3  = 3'($urandom);
      f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      f7  = f7 ^ (7'($urandom) & 7'h5F);
      imm = 12'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      drive(opc, f3, f7, imm, a, b);
      @(posedge clk); #1;
      check("random", ref_alu(opc, f3, f7, imm, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_top.md
# alu_top

Registered RV32I integer ALU for the single-cycle datapath. Each cycle it decodes opcode/Funct3/Funct7, computes the R-type or I-type arithmetic/logic/shift result from two register operands or a 12-bit immediate, and registers the result on RD. It sits between the register file and write-back, which samples RD one cycle after the operands are presented.

## Interface
- WIDTH, 32, datapath width; shift amounts are 5 bits; only 32 is required to be supported.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- RS1  input  WIDTH  first source operand.
- RS2  input  WIDTH  second source operand (R-type only).
- Funct3  input  3  operation select.
- Funct7  input  7  operation modifier; bit 5 selects SUB/SRA.
- Imm_reg  input  12  I-type immediate, instruction bits [31:20], i.e. {Funct7, rs2 field}.
- opcode  input  7  instruction opcode.
- RD  output  WIDTH  registered result.

## Operation
- opcode 7'b0110011 (OP, R-type), operand B = RS2:
  - Funct3 000: Funct7[5]=0 ADD, =1 SUB (RS1-RS2).
  - 001 SLL: RS1 << RS2[4:0].
  - 010 SLT: signed RS1<RS2 → 1 else 0.
  - 011 SLTU: unsigned compare → 1 else 0.
  - 100 XOR; 110 OR; 111 AND.
  - 101: Funct7[5]=0 SRL (logical), =1 SRA (arithmetic, sign-filled).
  - Funct7 bits other than bit 5 are ignored.
- opcode 7'b0010011 (OP-IMM, I-type), operand B = Imm_reg sign-extended to WIDTH (bit 11 replicated):
  - 000 ADDI (no SUBI; Funct7[5] ignored); 010 SLTI; 011 SLTIU (sign-extended immediate, compared unsigned); 100 XORI; 110 ORI; 111 ANDI.
  - 001 SLLI; 101 SRLI/SRAI selected by Imm_reg[10]; shift amount Imm_reg[4:0]; Imm_reg[11] and [9:5] ignored.
- Any other opcode: RD loads 0.
- Arithmetic is modulo 2^WIDTH; overflow and carry are discarded; no flags.
- SLT/SLTU results are zero-extended (only bit 0 can be 1).
- Shift by 0 returns RS1 unchanged.

## Timing
- RD is a register: inputs sampled on rising edge N, result visible after edge N; latency 1 cycle, throughput 1 per cycle, no handshake.
- rst high at an edge: RD ← 0 regardless of other inputs. Reset dominates any operation in flight.
- First edge with rst low computes normally from the inputs present at that edge.
- Inputs are treated as combinational; the block has no state beyond RD.

## Structure
- Shared package: WIDTH default, opcode constants (OP=7'b0110011, OP_IMM=7'b0010011), Funct3 encodings (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND).
- One combinational sub-module alu_core (operand A, operand B, op-select, arith-select → result); alu_top holds the decode, immediate sign-extension, operand-B mux and the RD register.

## Test plan
- Reset: drive RS1=32'hFFFF_FFFF, opcode=OP, rst=1 for two edges → RD=0; release rst, ADD 5+7 → RD=12 one edge later.
- R-type arithmetic: ADD 32'h7FFF_FFFF+1 → 32'h8000_0000; SUB 3-5 → 32'hFFFF_FFFE; SLT -1<1 → 1; SLTU 32'hFFFF_FFFF<1 → 0.
- Shifts: SLL 1 by RS2=32'h21 → 2 (only low 5 bits used); SRL 32'h8000_0000 by 4 → 32'h0800_0000; SRA same → 32'hF800_0000; SRAI via Imm_reg=12'h404 → 32'hF800_0000.
- I-type: ADDI RS1=10, Imm=12'hFFF → 9; SLTIU RS1=5, Imm=12'hFFF → 1; ANDI 32'h1234_5678 with 12'h0FF → 32'h78; XORI with 12'h800 → RS1 ^ 32'hFFFF_F800.
- Logic R-type: AND/OR/XOR of 32'hF0F0_F0F0 and 32'h0FF0_0FF0 → 32'h00F0_00F0 / 32'hFFF0_FFF0 / 32'hFF00_FF00.
- Unsupported opcode 7'b0000011 after a nonzero result → RD=0; back-to-back ops on consecutive edges each appear exactly one cycle after issue.
